// File: rtl/mac_feeder.sv
// mac_feeder: sample delay line and coefficient bank feeding the MAC datapath.
// Accepts one sample per frame, pulses start, then serves x/a taps until eof.
module mac_feeder #(
    parameter int NX = 18,
    parameter int NA = 36,
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          smp_valid_i,
    input  logic [NX-1:0] smp_i,
    output logic          smp_ready_o,
    input  logic          coef_we_i,
    input  logic [AW-1:0] coef_addr_i,
    input  logic [NA-1:0] coef_i,
    output logic          coef_err_o,
    input  logic [AW-1:0] i_i,
    input  logic          eof_i,
    output logic [NX-1:0] x_o,
    output logic [NA-1:0] a_o,
    output logic          stf_o,
    output logic          busy_o
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]             hd_q, hd_d;
    logic                      coef_err_q, coef_err_d;
    logic                      smp_we;
    logic                      coef_wr;
    logic [DEPTH-1:0][NX-1:0]  smp_mem_q;
    logic [DEPTH-1:0][NA-1:0]  coef_mem_q;
    logic [AW-1:0]             hd_inc;
    logic [AW-1:0]             rd_idx;

    assign hd_inc = hd_q + 1'b1;
    // AW-bit subtraction wraps naturally around the circular delay line
    assign rd_idx = hd_q - i_i;

    always_comb begin
        state_d    = state_q;
        hd_d       = hd_q;
        smp_we     = 1'b0;
        coef_wr    = 1'b0;
        coef_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                coef_wr = coef_we_i;
                if (smp_valid_i) begin
                    smp_we  = 1'b1;
                    hd_d    = hd_inc;
                    state_d = START;
                end
            end
            START: begin
                coef_err_d = coef_we_i;
                state_d    = WAIT;
            end
            WAIT: begin
                coef_err_d = coef_we_i;
                if (eof_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            hd_q       <= '0;
            coef_err_q <= 1'b0;
            smp_mem_q  <= '0;
            coef_mem_q <= '0;
        end else begin
            state_q    <= state_d;
            hd_q       <= hd_d;
            coef_err_q <= coef_err_d;
            if (smp_we) begin
                smp_mem_q[hd_inc] <= smp_i;
            end
            if (coef_wr) begin
                coef_mem_q[coef_addr_i] <= coef_i;
            end
        end
    end

    assign smp_ready_o = (state_q == IDLE);
    assign stf_o       = (state_q == START);
    assign busy_o      = (state_q != IDLE);
    assign coef_err_o  = coef_err_q;
    assign x_o         = smp_mem_q[rd_idx];
    assign a_o         = coef_mem_q[i_i];

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: scenario tasks with a sample scoreboard checked at
// each start-of-frame pulse.
module tb_mac_feeder;

    localparam int NX = 18;
    localparam int NA = 36;
    localparam int AW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          smp_valid_i;
    logic [NX-1:0] smp_i;
    logic          smp_ready_o;
    logic          coef_we_i;
    logic [AW-1:0] coef_addr_i;
    logic [NA-1:0] coef_i;
    logic          coef_err_o;
    logic [AW-1:0] i_i;
    logic          eof_i;
    logic [NX-1:0] x_o;
    logic [NA-1:0] a_o;
    logic          stf_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    logic [NX-1:0] exp_q[$];
    logic [NX-1:0] exp_x;

    always #5 clk_i = ~clk_i;

    mac_feeder #(.NX(NX), .NA(NA), .AW(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .smp_valid_i (smp_valid_i),
        .smp_i       (smp_i),
        .smp_ready_o (smp_ready_o),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_i      (coef_i),
        .coef_err_o  (coef_err_o),
        .i_i         (i_i),
        .eof_i       (eof_i),
        .x_o         (x_o),
        .a_o         (a_o),
        .stf_o       (stf_o),
        .busy_o      (busy_o)
    );

    task automatic coef_write(input logic [AW-1:0] ad, input logic [NA-1:0] d);
        @(negedge clk_i);
        coef_we_i = 1'b1;
        coef_addr_i = ad;
        coef_i = d;
        @(negedge clk_i);
        coef_we_i = 1'b0;
    endtask

    task automatic send_sample(input logic [NX-1:0] v, input bit do_eof);
        int n;
        n = 0;
        while (smp_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (smp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%b want=1", smp_ready_o);
        end
        smp_i = v;
        smp_valid_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back(v);
        @(negedge clk_i);
        smp_valid_i = 1'b0;
        i_i = '0;
        #1;
        checks++;
        if ({stf_o, busy_o, smp_ready_o} !== 3'b110) begin
            errors++;
            $display("FAIL start_flags got=%b want=110", {stf_o, busy_o, smp_ready_o});
        end
        exp_x = exp_q.pop_front();
        checks++;
        if (x_o !== exp_x) begin
            errors++;
            $display("FAIL start_x got=%0d want=%0d", x_o, exp_x);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if ({stf_o, busy_o, smp_ready_o} !== 3'b010) begin
            errors++;
            $display("FAIL wait_flags got=%b want=010", {stf_o, busy_o, smp_ready_o});
        end
        if (do_eof) begin
            eof_i = 1'b1;
            @(negedge clk_i);
            eof_i = 1'b0;
            #1;
            checks++;
            if ({busy_o, smp_ready_o} !== 2'b01) begin
                errors++;
                $display("FAIL eof_idle got=%b want=01", {busy_o, smp_ready_o});
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        smp_valid_i = 1'b0;
        smp_i = '0;
        coef_we_i = 1'b0;
        coef_addr_i = '0;
        coef_i = '0;
        i_i = '0;
        eof_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({stf_o, busy_o, coef_err_o, smp_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0001",
                     {stf_o, busy_o, coef_err_o, smp_ready_o});
        end
        checks++;
        if (x_o !== '0 || a_o !== '0) begin
            errors++;
            $display("FAIL reset_data x=%0d a=%0d want=0", x_o, a_o);
        end
    endtask

    task automatic test_coef();
        for (int k = 0; k < 4; k++) begin
            coef_write(AW'(k), NA'(k + 1));
        end
        i_i = 6'd2;
        #1;
        checks++;
        if (a_o !== 36'd3) begin
            errors++;
            $display("FAIL coef_read got=%0d want=3", a_o);
        end
        checks++;
        if (x_o !== '0) begin
            errors++;
            $display("FAIL x_cleared got=%0d want=0", x_o);
        end
        checks++;
        if (coef_err_o !== 1'b0) begin
            errors++;
            $display("FAIL coef_err_idle got=%b want=0", coef_err_o);
        end
    endtask

    task automatic test_samples();
        send_sample(18'd5, 1'b1);
        send_sample(18'd7, 1'b1);
        i_i = 6'd0;
        #1;
        checks++;
        if (x_o !== 18'd7) begin
            errors++;
            $display("FAIL tap0 got=%0d want=7", x_o);
        end
        i_i = 6'd1;
        #1;
        checks++;
        if (x_o !== 18'd5) begin
            errors++;
            $display("FAIL tap1 got=%0d want=5", x_o);
        end
        i_i = 6'd2;
        #1;
        checks++;
        if (x_o !== 18'd0) begin
            errors++;
            $display("FAIL tap2 got=%0d want=0", x_o);
        end
    endtask

    task automatic test_hold_and_coef_err();
        send_sample(18'd11, 1'b0);
        smp_i = 18'd22;
        smp_valid_i = 1'b1;
        i_i = 6'd0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (smp_ready_o !== 1'b0 || x_o !== 18'd11) begin
            errors++;
            $display("FAIL hold got ready=%b x=%0d want ready=0 x=11", smp_ready_o, x_o);
        end
        coef_we_i = 1'b1;
        coef_addr_i = '0;
        coef_i = 36'd99;
        @(negedge clk_i);
        coef_we_i = 1'b0;
        #1;
        checks++;
        if (coef_err_o !== 1'b1) begin
            errors++;
            $display("FAIL coef_err_pulse got=%b want=1", coef_err_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (coef_err_o !== 1'b0) begin
            errors++;
            $display("FAIL coef_err_one_cycle got=%b want=0", coef_err_o);
        end
        checks++;
        if (a_o !== 36'd1) begin
            errors++;
            $display("FAIL coef_protect got=%0d want=1", a_o);
        end
        eof_i = 1'b1;
        @(negedge clk_i);
        eof_i = 1'b0;
        #1;
        checks++;
        if (smp_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_eof got=%b want=1", smp_ready_o);
        end
        @(posedge clk_i);
        exp_q.push_back(18'd22);
        @(negedge clk_i);
        smp_valid_i = 1'b0;
        #1;
        exp_x = exp_q.pop_front();
        checks++;
        if (stf_o !== 1'b1 || x_o !== exp_x) begin
            errors++;
            $display("FAIL held_accept stf=%b x=%0d want stf=1 x=%0d", stf_o, x_o, exp_x);
        end
        @(negedge clk_i);
        eof_i = 1'b1;
        @(negedge clk_i);
        eof_i = 1'b0;
    endtask

    task automatic test_wrap();
        for (int v = 1; v <= 65; v++) begin
            send_sample(NX'(v), 1'b1);
        end
        i_i = 6'd0;
        #1;
        checks++;
        if (x_o !== 18'd65) begin
            errors++;
            $display("FAIL wrap_newest got=%0d want=65", x_o);
        end
        i_i = 6'd63;
        #1;
        checks++;
        if (x_o !== 18'd2) begin
            errors++;
            $display("FAIL wrap_oldest got=%0d want=2", x_o);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        send_sample(18'd33, 1'b0);
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({stf_o, busy_o, smp_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset_flags got=%b want=001", {stf_o, busy_o, smp_ready_o});
        end
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            i_i = AW'(k);
            #1;
            if (x_o !== '0 || a_o !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_clear got=%0d nonzero taps want=0", bad);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        eof_i = 1'b1;
        @(negedge clk_i);
        eof_i = 1'b0;
        #1;
        checks++;
        if ({stf_o, busy_o, smp_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL stray_eof got=%b want=001", {stf_o, busy_o, smp_ready_o});
        end
    endtask

    task automatic test_start_reset();
        smp_i = 18'd44;
        smp_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        smp_valid_i = 1'b0;
        #1;
        checks++;
        if (stf_o !== 1'b1) begin
            errors++;
            $display("FAIL start_before_reset got=%b want=1", stf_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (stf_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_stf_drop stf=%b busy=%b want 0 0", stf_o, busy_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_coef();
        test_samples();
        test_hold_and_coef_err();
        test_wrap();
        test_reset_mid();
        test_start_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Source side of the MAC datapath; feeds one filter output per accepted input sample.
- Accepts input samples over a valid/ready handshake and stores them in a circular delay line.
- Holds a writable coefficient bank.
- Pulses start to the MAC, then serves x/a operands combinationally from the index the MAC counter drives, until the MAC reports end of frame.

Parameters:
- NX, 18, sample width (matches MAC x_i).
- NA, 36, coefficient width (matches MAC a_i).
- AW, 6, index/address width; delay line and coefficient bank depth = 2**AW = 64.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset (0 = reset).
- smp_valid_i  input  1  new input sample present.
- smp_i  input  NX  input sample, two's complement.
- smp_ready_o  output  1  feeder can accept a sample.
- coef_we_i  input  1  coefficient write strobe.
- coef_addr_i  input  AW  coefficient write address.
- coef_i  input  NA  coefficient write data.
- coef_err_o  output  1  one-cycle pulse: coefficient write rejected (busy).
- i_i  input  AW  tap index from MAC counter.
- eof_i  input  1  end-of-frame pulse from MAC.
- x_o  output  NX  delayed sample x[k-i_i] to MAC.
- a_o  output  NA  coefficient a[i_i] to MAC.
- stf_o  output  1  start-of-frame pulse to MAC.
- busy_o  output  1  frame in progress.

Behaviour:
- Storage: smp_mem[0..63] (NX bits), coef_mem[0..63] (NA bits), head pointer hd (AW bits, index of newest sample).
- Reset (rst_i=0, asynchronous):
  - all smp_mem and coef_mem entries cleared to 0; hd=0; state=IDLE.
  - stf_o=0, busy_o=0, coef_err_o=0, smp_ready_o=1.
- Operand read: combinational, zero latency.
  - x_o = smp_mem[(hd - i_i) mod 64] (AW-bit wrap subtraction).
  - a_o = coef_mem[i_i].
  - Valid in every state.
- FSM states IDLE, START, WAIT:
  - IDLE: smp_ready_o=1, busy_o=0.
    - On smp_valid_i=1 at edge T: hd <= hd+1 (wraps 63->0), smp_mem[hd+1] <= smp_i, state <= START.
  - START: stf_o=1 for exactly this one cycle (cycle T+1); busy_o=1; smp_ready_o=0; next state WAIT unconditionally.
  - WAIT: busy_o=1, smp_ready_o=0, stf_o=0. On eof_i=1: state <= IDLE; a new sample is acceptable from the following cycle.
  - eof_i while in IDLE or START is ignored.
- Handshake rules:
  - smp_ready_o is a registered state decode; it does not depend on smp_valid_i.
  - A sample presented while smp_ready_o=0 is not consumed; the producer must hold it.
  - Back-to-back frames: minimum sample spacing is 3 cycles plus MAC frame length.
- Coefficient writes:
  - Accepted only in IDLE: coef_mem[coef_addr_i] <= coef_i at the edge.
  - In START/WAIT the write is dropped and coef_err_o pulses 1 the next cycle.
  - A write and a sample acceptance in the same IDLE cycle are both performed; the frame uses the new coefficient.
- Delay line wrap: after 64 accepted samples hd returns to its start value; the oldest sample is overwritten. The tap count supplied to the MAC must be at most 64.
- Reset mid-frame (in START or WAIT):
  - returns to IDLE and clears memories and hd immediately.
  - stf_o drops asynchronously.
  - any later MAC eof_i is ignored.
- No arithmetic beyond the AW-bit pointer add/sub; sample and coefficient data pass through unmodified.

Test Plan:
- Reset, then write coef_mem[0..3]=1,2,3,4 in IDLE; drive i_i=2 -> a_o=3; x_o=0 (cleared line).
- Accept smp_i=5, then 7 (eof_i after each frame); i_i=0 -> x_o=7; i_i=1 -> x_o=5; i_i=2 -> x_o=0.
- Sample accepted at edge T -> stf_o=1 only in cycle T+1; smp_ready_o=0 and busy_o=1 from T+1 until the cycle after eof_i.
- smp_valid_i held high during WAIT -> sample not consumed and hd unchanged; after eof_i it is accepted next cycle.
- coef_we_i with addr 0, data 99 during WAIT -> coef_mem[0] unchanged; coef_err_o=1 for one cycle.
- Push 65 samples of values 1..65 -> i_i=0 gives 65; i_i=63 gives 2 (wrap verified).
- Assert rst_i=0 mid-WAIT -> stf_o/busy_o=0 at once, smp_ready_o=1; x_o=0 and a_o=0 for all i_i.
